// File: rtl/sb_tx_pkg.sv
// Shared constants, state encoding and message lookup for the sideband
// pattern/message transmitter.
package sb_tx_pkg;

  localparam int unsigned PKT_UI_DEF = 64;
  localparam int unsigned GAP_UI_DEF = 32;

  localparam int unsigned MSG_NONE       = 0;
  localparam int unsigned MSG_SBINIT_OOR = 1;
  localparam int unsigned MSG_DONE_REQ   = 2;
  localparam int unsigned MSG_DONE_RESP  = 3;

  localparam logic [7:0] OPCODE = 8'h12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_MSG     = 2'd2,
    ST_GAP     = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic [7:0] msgcode;
    logic [7:0] subcode;
    logic       known;
  } msg_lut_t;

  function automatic msg_lut_t msg_lookup(input int unsigned code);
    msg_lut_t r;
    r = '0;
    case (code)
      MSG_SBINIT_OOR: begin r.msgcode = 8'h91; r.subcode = 8'h00; r.known = 1'b1; end
      MSG_DONE_REQ:   begin r.msgcode = 8'h95; r.subcode = 8'h01; r.known = 1'b1; end
      MSG_DONE_RESP:  begin r.msgcode = 8'h9A; r.subcode = 8'h01; r.known = 1'b1; end
      default:        r = '0;
    endcase
    return r;
  endfunction

  // Bit 63 makes the total count of ones in the packet even.
  function automatic logic even_parity(input logic [62:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sb_pkt_builder.sv
// Combinational packet assembly: encoded message code -> 64-bit sideband
// packet, plus a flag for non-zero codes with no packet definition.
module sb_pkt_builder
  import sb_tx_pkg::*;
#(
  parameter int unsigned SB_MSG_WIDTH = 4
) (
  input  logic [SB_MSG_WIDTH-1:0] i_code,
  output logic [63:0]             o_pkt,
  output logic                    o_unsupported
);

  msg_lut_t    lut;
  logic [62:0] body;

  always_comb begin
    lut           = msg_lookup(32'(i_code));
    body          = {39'd0, lut.subcode, lut.msgcode, OPCODE};
    o_pkt         = {even_parity(body), body};
    o_unsupported = (i_code != '0) && !lut.known;
  end

endmodule

// File: rtl/sb_pattern_msg_tx.sv
// Sideband transmitter: sends a clock-pattern burst or an encoded message
// packet serially (LSB first), each followed by an idle gap.
module sb_pattern_msg_tx
  import sb_tx_pkg::*;
#(
  parameter int unsigned SB_MSG_WIDTH = 4,
  parameter int unsigned PKT_UI       = PKT_UI_DEF,
  parameter int unsigned GAP_UI       = GAP_UI_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start_pattern_req,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
  output logic                    o_start_pattern_done,
  output logic                    o_SB_Busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_tx_data,
  output logic                    o_tx_clk_en,
  output logic                    o_msg_err
);

  localparam int unsigned      CNT_W    = $clog2(PKT_UI + GAP_UI);
  localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_UI - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_UI - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      shreg, shreg_nxt;
  logic             is_pat, is_pat_nxt;
  logic             data_nxt, clk_en_nxt, busy_nxt, done_nxt, fall_nxt, err_nxt;
  logic [63:0]      built_pkt;
  logic             built_unsup;

  sb_pkt_builder #(
    .SB_MSG_WIDTH(SB_MSG_WIDTH)
  ) u_pkt_builder (
    .i_code       (i_encoded_SB_msg),
    .o_pkt        (built_pkt),
    .o_unsupported(built_unsup)
  );

  // Outputs are computed one cycle ahead so every port comes from a flop;
  // bit 0 is issued at acceptance and the shift register holds the rest.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    shreg_nxt  = shreg;
    is_pat_nxt = is_pat;
    data_nxt   = 1'b0;
    clk_en_nxt = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    err_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (i_start_pattern_req) begin
          state_nxt  = ST_PATTERN;
          is_pat_nxt = 1'b1;
          data_nxt   = 1'b1;
          clk_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end else if (i_tx_msg_valid && built_unsup) begin
          err_nxt = 1'b1;
        end else if (i_tx_msg_valid && (i_encoded_SB_msg != '0)) begin
          state_nxt  = ST_MSG;
          is_pat_nxt = 1'b0;
          shreg_nxt  = built_pkt >> 1;
          data_nxt   = built_pkt[0];
          clk_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end
      end
      ST_PATTERN: begin
        busy_nxt = 1'b1;
        if (cnt == PKT_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          data_nxt   = cnt[0];
          clk_en_nxt = 1'b1;
        end
      end
      ST_MSG: begin
        busy_nxt = 1'b1;
        if (cnt == PKT_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          data_nxt   = shreg[0];
          shreg_nxt  = shreg >> 1;
          clk_en_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
          done_nxt  = is_pat;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      shreg                <= '0;
      is_pat               <= 1'b0;
      o_tx_data            <= 1'b0;
      o_tx_clk_en          <= 1'b0;
      o_SB_Busy            <= 1'b0;
      o_start_pattern_done <= 1'b0;
      o_falling_edge_busy  <= 1'b0;
      o_msg_err            <= 1'b0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      shreg                <= shreg_nxt;
      is_pat               <= is_pat_nxt;
      o_tx_data            <= data_nxt;
      o_tx_clk_en          <= clk_en_nxt;
      o_SB_Busy            <= busy_nxt;
      o_start_pattern_done <= done_nxt;
      o_falling_edge_busy  <= fall_nxt;
      o_msg_err            <= err_nxt;
    end
  end

endmodule
